// File: rtl/alu_vector_sequencer.sv
// alu_vector_sequencer
//   Stimulus stage for the operand-memory ALU wrapper. On start it holds
//   initialise high for INIT_CYCLES cycles, then sweeps every
//   (address_a, address_b, function) triple over the 18 Hack ALU functions.
//   Each vector is offered on a valid/ready handshake.
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   start, abort          begin sweep (IDLE/DONE only) / return to IDLE
//   step_mode, step       single-step pacing: one vector per step pulse
//   ready                 downstream accepts the current vector
//   initialise            operand-memory preload strobe
//   address_a, address_b  operand addresses
//   zx,nx,zy,ny,f,no      ALU control bits decoded from func_idx
//   func_idx              current function index 0..17
//   valid, busy, done     handshake and status flags
module alu_vector_sequencer #(
  parameter int unsigned INIT_CYCLES = 4,
  parameter int unsigned A_FIRST     = 0,
  parameter int unsigned A_LAST      = 31,
  parameter int unsigned B_FIRST     = 0,
  parameter int unsigned B_LAST      = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       step_mode,
  input  logic       step,
  input  logic       ready,
  output logic       initialise,
  output logic [4:0] address_a,
  output logic [4:0] address_b,
  output logic       zx,
  output logic       nx,
  output logic       zy,
  output logic       ny,
  output logic       f,
  output logic       no,
  output logic [4:0] func_idx,
  output logic       valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, INIT, RUN, WAIT, DONE} state_t;

  localparam logic [4:0]  AF       = 5'(A_FIRST);
  localparam logic [4:0]  AL       = 5'(A_LAST);
  localparam logic [4:0]  BF       = 5'(B_FIRST);
  localparam logic [4:0]  BL       = 5'(B_LAST);
  localparam logic [4:0]  FN_LAST  = 5'd17;
  localparam logic [31:0] INIT_END = 32'(INIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [4:0]  a_nxt, b_nxt, fn_nxt;
  logic [31:0] init_cnt, cnt_nxt;
  logic [5:0]  ctrl;
  logic        last_vec;

  function automatic logic [5:0] ctrl_of(input logic [4:0] idx);
    case (idx)
      5'd0:    ctrl_of = 6'b101010;
      5'd1:    ctrl_of = 6'b111111;
      5'd2:    ctrl_of = 6'b111010;
      5'd3:    ctrl_of = 6'b001100;
      5'd4:    ctrl_of = 6'b110000;
      5'd5:    ctrl_of = 6'b001101;
      5'd6:    ctrl_of = 6'b110001;
      5'd7:    ctrl_of = 6'b001111;
      5'd8:    ctrl_of = 6'b110011;
      5'd9:    ctrl_of = 6'b011111;
      5'd10:   ctrl_of = 6'b110111;
      5'd11:   ctrl_of = 6'b001110;
      5'd12:   ctrl_of = 6'b110010;
      5'd13:   ctrl_of = 6'b000010;
      5'd14:   ctrl_of = 6'b010011;
      5'd15:   ctrl_of = 6'b000111;
      5'd16:   ctrl_of = 6'b000000;
      5'd17:   ctrl_of = 6'b010101;
      default: ctrl_of = 6'b101010;
    endcase
  endfunction

  assign last_vec = (address_a == AL) && (address_b == BL) && (func_idx == FN_LAST);

  always_comb begin
    state_nxt = state;
    a_nxt     = address_a;
    b_nxt     = address_b;
    fn_nxt    = func_idx;
    cnt_nxt   = init_cnt;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_nxt = INIT;
            a_nxt     = AF;
            b_nxt     = BF;
            fn_nxt    = '0;
            cnt_nxt   = '0;
          end
        end
        INIT: begin
          if (init_cnt == INIT_END) state_nxt = RUN;
          else                      cnt_nxt   = init_cnt + 32'd1;
        end
        RUN: begin
          if (ready) begin
            // The final vector goes straight to DONE with counters left in place.
            if (last_vec) begin
              state_nxt = DONE;
            end else begin
              if (func_idx == FN_LAST) begin
                fn_nxt = '0;
                if (address_b == BL) begin
                  b_nxt = BF;
                  a_nxt = address_a + 5'd1;
                end else begin
                  b_nxt = address_b + 5'd1;
                end
              end else begin
                fn_nxt = func_idx + 5'd1;
              end
              if (step_mode) state_nxt = WAIT;
            end
          end
        end
        WAIT: begin
          if (step || !step_mode) state_nxt = RUN;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      address_a <= AF;
      address_b <= BF;
      func_idx  <= '0;
      ctrl      <= 6'b101010;
      init_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      address_a <= a_nxt;
      address_b <= b_nxt;
      func_idx  <= fn_nxt;
      // Decode the next index so ctrl bits update on the same edge as func_idx.
      ctrl      <= ctrl_of(fn_nxt);
      init_cnt  <= cnt_nxt;
    end
  end

  assign {zx, nx, zy, ny, f, no} = ctrl;
  assign initialise = (state == INIT);
  assign valid      = (state == RUN);
  assign busy       = (state == INIT) || (state == RUN) || (state == WAIT);
  assign done       = (state == DONE);

endmodule
